// File: rtl/axil_lite_master.sv
// AXI4-Lite initiator: one command in flight, turned into a single
// AW+W+B or AR+R transaction with the response handed back to the requester.
module axil_lite_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              axi_aclk,
    input  logic              m00_axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] m00_axi_awaddr,
    output logic              m00_axi_awvalid,
    input  logic              m00_axi_awready,
    output logic [DATA_W-1:0] m00_axi_wdata,
    output logic              m00_axi_wvalid,
    input  logic              m00_axi_wready,
    input  logic [1:0]        m00_axi_bresp,
    input  logic              m00_axi_bvalid,
    output logic              m00_axi_bready,
    output logic [ADDR_W-1:0] m00_axi_araddr,
    output logic              m00_axi_arvalid,
    input  logic              m00_axi_arready,
    input  logic [DATA_W-1:0] m00_axi_rdata,
    input  logic [1:0]        m00_axi_rresp,
    input  logic              m00_axi_rvalid,
    output logic              m00_axi_rready
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] CMAX  = '1;

    typedef enum logic [2:0] {
        IDLE, WR, WR_B, RD_A, RD_R, RSP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              waiting;

    // Gate with reset so the requester never sees a ready while held in reset
    assign cmd_ready       = (state_q == IDLE) & m00_axi_aresetn;
    assign rsp_valid       = (state_q == RSP);
    assign m00_axi_bready  = (state_q == WR_B);
    assign m00_axi_rready  = (state_q == RD_R);
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_arvalid = arvalid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_resp        = rsp_resp_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign timeout_err     = tmo_q;

    assign waiting = (state_q == WR) || (state_q == WR_B) ||
                     (state_q == RD_A) || (state_q == RD_R);

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_A;
                    end
                end
            end
            WR: begin
                if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m00_axi_wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_B;
            end
            WR_B: begin
                if (m00_axi_bvalid) begin
                    rsp_write_d = 1'b1;
                    rsp_resp_d  = m00_axi_bresp;
                    rsp_rdata_d = '0;
                    state_d     = RSP;
                end
            end
            RD_A: begin
                if (m00_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (m00_axi_rvalid) begin
                    rsp_write_d = 1'b0;
                    rsp_resp_d  = m00_axi_rresp;
                    rsp_rdata_d = m00_axi_rdata;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Wait counter restarts on every state change and saturates
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d >= TMO_C) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// Bench for axil_lite_master: adder-slave model, scoreboard and
// response monitor, directed corner cases then randomized traffic.
module tb_axil_lite_master;

    localparam int TMO = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        axi_aclk = 1'b0;
    logic        m00_axi_aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic        timeout_err;
    logic [31:0] m00_axi_awaddr;
    logic        m00_axi_awvalid;
    logic        m00_axi_awready = 1'b0;
    logic [31:0] m00_axi_wdata;
    logic        m00_axi_wvalid;
    logic        m00_axi_wready = 1'b0;
    logic [1:0]  m00_axi_bresp = '0;
    logic        m00_axi_bvalid = 1'b0;
    logic        m00_axi_bready;
    logic [31:0] m00_axi_araddr;
    logic        m00_axi_arvalid;
    logic        m00_axi_arready = 1'b0;
    logic [31:0] m00_axi_rdata = '0;
    logic [1:0]  m00_axi_rresp = '0;
    logic        m00_axi_rvalid = 1'b0;
    logic        m00_axi_rready;

    always #5 axi_aclk = ~axi_aclk;

    axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .axi_aclk(axi_aclk), .m00_axi_aresetn(m00_axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .timeout_err(timeout_err),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awvalid(m00_axi_awvalid),
        .m00_axi_awready(m00_axi_awready),
        .m00_axi_wdata(m00_axi_wdata), .m00_axi_wvalid(m00_axi_wvalid),
        .m00_axi_wready(m00_axi_wready),
        .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
        .m00_axi_bready(m00_axi_bready),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    // Reference model of the adder peripheral
    logic [31:0] m0 = '0, m1 = '0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        longint s, u;
        logic [31:0] r;
        s = longint'($signed(m0)) + longint'($signed(m1));
        u = longint'(m0) + longint'(m1);
        case (a[3:2])
            2'd0: r = m0;
            2'd1: r = m1;
            2'd2: r = m0 + m1;
            default: begin
                r = '0;
                r[31] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r[0]  = (u >= 64'h1_0000_0000);
            end
        endcase
        return r;
    endfunction

    // Slave configuration and state
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit ar_never = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int rsp_hold = 0;

    logic [31:0] sreg0 = '0, sreg1 = '0;
    logic [31:0] s_awaddr, s_wdata, s_araddr, r_pend_data;
    bit got_aw, got_w, b_pend, r_pend;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    int aw_w, w_w, b_w, ar_w, r_w;

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        logic [32:0] s;
        logic ovf;
        s = {1'b0, sreg0} + {1'b0, sreg1};
        ovf = (sreg0[31] == sreg1[31]) && (s[31] != sreg0[31]);
        case (a[3:2])
            2'd0: return sreg0;
            2'd1: return sreg1;
            2'd2: return s[31:0];
            default: return {ovf, 30'b0, s[32]};
        endcase
    endfunction

    initial begin : slave
        forever begin
            @(negedge axi_aclk);
            if (!m00_axi_aresetn) begin
                m00_axi_awready = 0; m00_axi_wready = 0; m00_axi_arready = 0;
                m00_axi_bvalid = 0; m00_axi_rvalid = 0;
                {got_aw, got_w, b_pend, r_pend} = '0;
                {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
                {p_awv, p_wv, p_arv} = '0;
                aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
            end else begin
                if (p_awv && !aw_hs) begin
                    chk("awvalid_held", 64'(m00_axi_awvalid), 64'(1));
                    chk("awaddr_stable", 64'(m00_axi_awaddr), 64'(p_awaddr));
                end
                if (p_wv && !w_hs) begin
                    chk("wvalid_held", 64'(m00_axi_wvalid), 64'(1));
                    chk("wdata_stable", 64'(m00_axi_wdata), 64'(p_wdata));
                end
                if (p_arv && !ar_hs) begin
                    chk("arvalid_held", 64'(m00_axi_arvalid), 64'(1));
                    chk("araddr_stable", 64'(m00_axi_araddr), 64'(p_araddr));
                end
                if (m00_axi_bready)
                    chk("bready_after_aw_w",
                        64'({m00_axi_awvalid, m00_axi_wvalid}), 64'(0));
                if (cmd_ready)
                    chk("no_ready_in_idle",
                        64'({m00_axi_bready, m00_axi_rready}), 64'(0));

                if (aw_hs) begin got_aw = 1; m00_axi_awready = 0; end
                if (w_hs) begin got_w = 1; m00_axi_wready = 0; end
                if (b_hs) m00_axi_bvalid = 0;
                if (ar_hs) begin
                    m00_axi_arready = 0;
                    r_pend = 1; r_w = 0;
                    r_pend_data = slave_read(s_araddr);
                end
                if (r_hs) m00_axi_rvalid = 0;
                if (got_aw && got_w) begin
                    if (s_awaddr[3:2] == 2'd0) sreg0 = s_wdata;
                    if (s_awaddr[3:2] == 2'd1) sreg1 = s_wdata;
                    got_aw = 0; got_w = 0; b_pend = 1; b_w = 0;
                end

                if (m00_axi_awvalid && !m00_axi_awready && !got_aw) begin
                    if (aw_w >= aw_dly) begin
                        m00_axi_awready = 1; s_awaddr = m00_axi_awaddr; aw_w = 0;
                    end else aw_w++;
                end
                if (m00_axi_wvalid && !m00_axi_wready && !got_w) begin
                    if (w_w >= w_dly) begin
                        m00_axi_wready = 1; s_wdata = m00_axi_wdata; w_w = 0;
                    end else w_w++;
                end
                if (m00_axi_arvalid && !m00_axi_arready && !r_pend && !ar_never) begin
                    if (ar_w >= ar_dly) begin
                        m00_axi_arready = 1; s_araddr = m00_axi_araddr; ar_w = 0;
                    end else ar_w++;
                end
                if (b_pend && !m00_axi_bvalid) begin
                    if (b_w >= b_dly) begin
                        m00_axi_bvalid = 1; m00_axi_bresp = bresp_cfg;
                        b_pend = 0; b_w = 0;
                    end else b_w++;
                end
                if (r_pend && !m00_axi_rvalid) begin
                    if (r_w >= r_dly) begin
                        m00_axi_rvalid = 1; m00_axi_rresp = rresp_cfg;
                        m00_axi_rdata = r_pend_data;
                        r_pend = 0; r_w = 0;
                    end else r_w++;
                end

                aw_hs = m00_axi_awvalid && m00_axi_awready;
                w_hs  = m00_axi_wvalid && m00_axi_wready;
                ar_hs = m00_axi_arvalid && m00_axi_arready;
                b_hs  = m00_axi_bvalid && m00_axi_bready;
                r_hs  = m00_axi_rvalid && m00_axi_rready;
                p_awv = m00_axi_awvalid; p_awaddr = m00_axi_awaddr;
                p_wv  = m00_axi_wvalid;  p_wdata  = m00_axi_wdata;
                p_arv = m00_axi_arvalid; p_araddr = m00_axi_araddr;
            end
        end
    end

    initial begin : monitor
        bit in_rsp, done;
        int hc;
        exp_t snap, cur, e;
        in_rsp = 0; done = 0; hc = 0;
        forever begin
            @(negedge axi_aclk);
            if (!m00_axi_aresetn) begin
                rsp_ready = 0; in_rsp = 0; done = 0;
            end else begin
                if (done) begin
                    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
                    chk("idle_after_rsp", 64'(cmd_ready), 64'(1));
                    done = 0;
                end
                if (rsp_valid) begin
                    cur = {rsp_write, rsp_resp, rsp_rdata};
                    chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'(0));
                    if (!in_rsp) begin
                        in_rsp = 1; hc = 0; snap = cur;
                    end else chk("rsp_stable", 64'(cur), 64'(snap));
                    if (hc >= rsp_hold) begin
                        rsp_ready = 1; in_rsp = 0; done = 1;
                        if (sb.size() == 0) begin
                            chk("unexpected_rsp", 64'(1), 64'(0));
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        end
                    end else begin
                        rsp_ready = 0; hc++;
                    end
                end else rsp_ready = 0;
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        int n;
        bresp_cfg = resp; rresp_cfg = resp;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge axi_aclk); n++; end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 64'(0), 64'(1));
            cmd_valid = 0;
            return;
        end
        e.wr = wr; e.resp = resp;
        e.rdata = wr ? 32'h0 : model_read(addr);
        if (wr && addr[3:2] == 2'd0) m0 = data;
        if (wr && addr[3:2] == 2'd1) m1 = data;
        sb.push_back(e);
        @(negedge axi_aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge axi_aclk); n++;
        end
        if (n >= 500) chk("rsp_wait_timeout", 64'(0), 64'(1));
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] resp);
        issue(wr, addr, data, resp);
        wait_done();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_valids", 64'({m00_axi_awvalid, m00_axi_wvalid,
            m00_axi_arvalid, m00_axi_bready, m00_axi_rready, rsp_valid}), 64'(0));
        chk("rst_addr_data", 64'({m00_axi_awaddr, m00_axi_wdata}), 64'(0));
        chk("rst_rsp", 64'({timeout_err, rsp_write, rsp_resp, rsp_rdata}), 64'(0));
        repeat (3) @(negedge axi_aclk);
        m00_axi_aresetn = 1;
        @(negedge axi_aclk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

        // Basic add
        txn(1, BASE, 32'h5, 2'b00);
        txn(1, BASE + 4, 32'h7, 2'b00);
        txn(0, BASE + 8, 32'h0, 2'b00);
        chk("slave_reg2", 64'(slave_read(BASE + 8)), 64'(32'hC));

        // Signed overflow
        txn(1, BASE, 32'h7FFF_FFFF, 2'b00);
        txn(1, BASE + 4, 32'h1, 2'b00);
        txn(0, BASE + 12, 32'h0, 2'b00);
        txn(0, BASE + 8, 32'h0, 2'b00);

        // AW late, W immediate
        aw_dly = 3; w_dly = 0;
        issue(1, BASE, 32'h1234_5678, 2'b00);
        chk("wr_lat_valids", 64'({m00_axi_awvalid, m00_axi_wvalid}), 64'(2'b11));
        @(negedge axi_aclk);
        chk("w_dropped", 64'({m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready}),
            64'(3'b100));
        repeat (2) @(negedge axi_aclk);
        chk("aw_still_held", 64'({m00_axi_awvalid, m00_axi_bready}), 64'(2'b10));
        chk("awaddr_held", 64'(m00_axi_awaddr), 64'(BASE));
        @(negedge axi_aclk);
        chk("aw_done_bready", 64'({m00_axi_awvalid, m00_axi_bready}), 64'(2'b01));
        wait_done();
        aw_dly = 0;

        // SLVERR read with a slow requester
        rsp_hold = 5;
        txn(0, BASE, 32'h0, 2'b10);
        rsp_hold = 0;

        // Arready never comes
        ar_never = 1;
        issue(0, BASE + 4, 32'h0, 2'b00);
        sb.delete();
        chk("tmo_arvalid_rise", 64'({m00_axi_arvalid, timeout_err}), 64'(2'b10));
        for (int k = 1; k <= TMO + 3; k++) begin
            @(negedge axi_aclk);
            if (k == TMO - 1) chk("tmo_not_yet", 64'(timeout_err), 64'(0));
            if (k == TMO) chk("tmo_set", 64'(timeout_err), 64'(1));
        end
        chk("tmo_sticky_waiting",
            64'({timeout_err, m00_axi_arvalid, rsp_valid}), 64'(3'b110));
        #2 m00_axi_aresetn = 0;
        #1 chk("tmo_cleared", 64'({timeout_err, m00_axi_arvalid}), 64'(0));
        @(negedge axi_aclk);
        ar_never = 0;
        m00_axi_aresetn = 1;
        @(negedge axi_aclk);

        // Reset while waiting for B
        b_dly = 8;
        issue(1, BASE + 4, 32'h0000_00AA, 2'b00);
        n = 0;
        while (!m00_axi_bready && n < 50) begin @(negedge axi_aclk); n++; end
        chk("reached_wr_b", 64'(m00_axi_bready), 64'(1));
        #2 m00_axi_aresetn = 0;
        #1 chk("async_rst_outs", 64'({m00_axi_awvalid, m00_axi_wvalid,
            m00_axi_arvalid, m00_axi_bready, m00_axi_rready, rsp_valid,
            cmd_ready}), 64'(0));
        sb.delete();
        repeat (2) @(negedge axi_aclk);
        m00_axi_aresetn = 1;
        b_dly = 0;
        @(negedge axi_aclk);
        txn(1, BASE, 32'h0000_0011, 2'b00);
        txn(0, BASE + 8, 32'h0, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit wr;
            logic [31:0] a;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3); rsp_hold = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            a = BASE + 32'(4 * (wr ? $urandom_range(0, 1) : $urandom_range(0, 3)));
            txn(wr, a, $urandom, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
        end

        repeat (3) @(negedge axi_aclk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axil_lite_master.md
Name: axil_lite_master

Overview:
- AXI4-Lite initiator that drives the adder slave from a simple single-outstanding command/response interface.
- Converts each accepted command into exactly one AXI-Lite write (AW+W+B) or read (AR+R) transaction.
- Returns the slave's response and read data to the requester.
- Sits between the test/CPU-side sequencer and the AXI-Lite slave port of the adder peripheral.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width.
- TIMEOUT, 16, max cycles any single channel handshake may wait before the sticky timeout flag sets; must be ≥2.

Ports:
- axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester consumes response
- rsp_write  out  1  response belongs to a write
- rsp_resp  out  2  BRESP or RRESP of the transaction
- rsp_rdata  out  DATA_W  RDATA (0 for writes)
- timeout_err  out  1  sticky: some handshake exceeded TIMEOUT cycles
- m00_axi_awaddr  out  ADDR_W;  m00_axi_awvalid  out 1;  m00_axi_awready  in 1
- m00_axi_wdata  out  DATA_W;  m00_axi_wvalid  out 1;  m00_axi_wready  in 1
- m00_axi_bresp  in 2;  m00_axi_bvalid  in 1;  m00_axi_bready  out 1
- m00_axi_araddr  out  ADDR_W;  m00_axi_arvalid  out 1;  m00_axi_arready  in 1
- m00_axi_rdata  in  DATA_W;  m00_axi_rresp  in 2;  m00_axi_rvalid  in 1;  m00_axi_rready  out 1

Behaviour:
- Reset (async assert, sync release): state=IDLE; every valid/ready output = 0; all address, data and response outputs = 0; timeout_err = 0; cmd_ready = 0 during reset.
- Reset mid-transaction: abandon immediately and return to IDLE; no response is produced.
- FSM states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- cmd_ready = 1 only in IDLE.
- Command accept registers cmd_* and transitions next cycle:
  - write → WR, awvalid=wvalid=1;
  - read → RD_A, arvalid=1.
- AXI output latency from accept: 1 cycle.
- WR:
  - awvalid and wvalid each drop in the cycle after their own ready is sampled high; they are independent.
  - AW-before-W, W-before-AW and simultaneous acceptance are all legal.
  - Go to WR_B when both have been accepted. Do not wait for bvalid in WR.
- WR_B: bready=1; on bvalid capture bresp, set rsp_write=1, rsp_rdata=0, go to RSP.
- RD_A: arvalid held until arready, then RD_R with arvalid=0.
- RD_R: rready=1; on rvalid capture rdata/rresp, rsp_write=0, go to RSP.
- No valid is ever withdrawn before its ready.
- awaddr/wdata/araddr are loaded only on command accept and then held until the next command of the same type; they never change while the matching valid is 0 otherwise.
- bready/rready are asserted only in WR_B/RD_R; they are never 1 in IDLE.
- RSP:
  - rsp_valid=1 with rsp_* stable until rsp_ready.
  - Then IDLE with rsp_valid=0 the next cycle.
  - Back-to-back commands therefore have a minimum of one IDLE cycle between them.
- Timeout:
  - An 8-bit-min saturating counter clears on each state entry and counts each cycle in WR, WR_B, RD_A and RD_R.
  - Reaching TIMEOUT sets timeout_err, which is sticky until reset.
  - The transaction keeps waiting; it is never aborted.
- rresp/bresp are forwarded unmodified, including SLVERR 2'b10.
- rsp_rdata is full width with no width conversion.

Test Plan:
- Zero-wait slave, cmd write 0x0000_0005 → BASE, then 0x0000_0007 → BASE+4, then read BASE+8 → rsp_rdata=0x0000_000C, rsp_resp=00; slave reg2=0xC.
- Write 0x7FFF_FFFF → BASE, 0x0000_0001 → BASE+4, read BASE+12 → rsp_rdata[31]=1 (signed overflow); read BASE+8 → 0x8000_0000.
- awready delayed 3 cycles, wready immediate → wvalid low after 1 cycle, awvalid held for 3 cycles with awaddr stable, bready rises only after both are accepted, single response returned.
- rvalid returned with rresp=2'b10 while rsp_ready is held low 5 cycles → rsp_valid stays 1 with rdata/resp stable, cmd_ready=0 throughout; IDLE the cycle after rsp_ready.
- Slave never asserts arready → timeout_err=1 exactly TIMEOUT cycles after arvalid rises; arvalid stays 1; no rsp_valid.
- aresetn pulsed low while in WR_B → all AXI valids/readies and rsp_valid = 0 asynchronously; after release a fresh write completes normally.
